// File: rtl/trees_pkg.sv
// ---------------------------------------------------------------------------
// trees_pkg
// Shared definitions for the tree objects: object count, index width and the
// collision detector's FSM state type. The trees mux takes its TREES_COUNT
// from here so the mux and the detector cannot disagree on the object count.
// ---------------------------------------------------------------------------
package trees_pkg;

    localparam int TREES_COUNT = 16;
    localparam int TREE_IDX_W  = $clog2(TREES_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for the first frame after reset
        ARMED = 2'd1,   // detection enabled for this frame
        HIT   = 2'd2,   // one-cycle collision report
        DONE  = 2'd3    // collision already reported this frame
    } coll_state_e;

endpackage

// File: rtl/tree_priority_encoder.sv
// ---------------------------------------------------------------------------
// tree_priority_encoder
// Picks the lowest-index set bit of the per-tree coverage vector, matching
// the priority order of the trees mux.
// Ports:
//   req_i   [TREES_COUNT]  per-tree coverage of the current pixel
//   idx_o   [IDX_W]        lowest set bit index (0 when nothing is set)
//   valid_o                at least one bit of req_i is set
// ---------------------------------------------------------------------------
module tree_priority_encoder #(
    parameter int TREES_COUNT = trees_pkg::TREES_COUNT,
    parameter int IDX_W       = $clog2(TREES_COUNT)
) (
    input  logic [TREES_COUNT-1:0] req_i,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   valid_o
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = TREES_COUNT - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tree_collision_detector.sv
// ---------------------------------------------------------------------------
// tree_collision_detector
// Detects the player sprite overlapping any tree, reports at most one
// collision per frame, latches which tree was hit, blocks the player until
// the next frame and keeps a saturating collision count.
//
// Optional feature: define TREE_COLLISION_DEBOUNCE_EN to require MIN_OVERLAP
// consecutive overlap pixels before a collision is reported. Without it the
// first overlap pixel of an armed frame qualifies and no run counter exists.
//
// Ports:
//   clk                   pixel clock, rising edge
//   resetN                asynchronous active-low reset
//   startOfFrame          one-cycle frame start pulse
//   playerDrawingRequest  player covers current pixel
//   treesDrawingRequest   some tree covers current pixel (trees mux output)
//   treesInsideRectangle  per-tree coverage of current pixel
//   collisionPulse        one-cycle pulse per reported collision
//   collidedTreeIdx       tree index of the last collision (held)
//   playerBlocked         high from the collision until next startOfFrame
//   collisionCount        saturating collision count since reset
// ---------------------------------------------------------------------------
module tree_collision_detector
    import trees_pkg::*;
#(
    parameter int TREES_COUNT = trees_pkg::TREES_COUNT,
    parameter int COUNT_WIDTH = 8,
    parameter int MIN_OVERLAP = 4
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           startOfFrame,
    input  logic                           playerDrawingRequest,
    input  logic                           treesDrawingRequest,
    input  logic [TREES_COUNT-1:0]         treesInsideRectangle,
    output logic                           collisionPulse,
    output logic [$clog2(TREES_COUNT)-1:0] collidedTreeIdx,
    output logic                           playerBlocked,
    output logic [COUNT_WIDTH-1:0]         collisionCount
);

    localparam int IDX_W = $clog2(TREES_COUNT);

    coll_state_e            state_q;
    logic                   pulse_q;
    logic                   blocked_q;
    logic [IDX_W-1:0]       idx_q;
    logic [COUNT_WIDTH-1:0] count_q;

    logic                   overlap;
    logic                   qualify;
    logic [IDX_W-1:0]       enc_idx;
    logic                   enc_valid;

    assign overlap = playerDrawingRequest & treesDrawingRequest;

    tree_priority_encoder #(
        .TREES_COUNT (TREES_COUNT),
        .IDX_W       (IDX_W)
    ) u_prio (
        .req_i   (treesInsideRectangle),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

`ifdef TREE_COLLISION_DEBOUNCE_EN
    // Run length of consecutive overlap pixels in the armed frame. The cycle
    // that would bring the run to MIN_OVERLAP is the qualifying one, so the
    // counter itself never has to hold MIN_OVERLAP.
    localparam int RUN_W = (MIN_OVERLAP > 0) ? $clog2(MIN_OVERLAP + 1) : 1;

    logic [RUN_W-1:0] run_q, run_d;

    always_comb begin
        run_d   = '0;
        qualify = 1'b0;
        if (state_q == ARMED && !startOfFrame && overlap) begin
            if (int'(run_q) + 1 >= MIN_OVERLAP) qualify = 1'b1;
            else                                run_d   = run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) run_q <= '0;
        else         run_q <= run_d;
    end
`else
    assign qualify = (state_q == ARMED) && !startOfFrame && overlap;
`endif

    // Frame start wins over everything: it re-arms from any state and drops
    // the block, discarding a same-cycle overlap.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            pulse_q   <= 1'b0;
            blocked_q <= 1'b0;
            idx_q     <= '0;
            count_q   <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (startOfFrame) begin
                state_q   <= ARMED;
                blocked_q <= 1'b0;
            end else begin
                case (state_q)
                    ARMED: begin
                        if (qualify) begin
                            state_q   <= HIT;
                            pulse_q   <= 1'b1;
                            blocked_q <= 1'b1;
                            // Without any coverage bit keep the previous index.
                            if (enc_valid) idx_q <= enc_idx;
                            if (count_q != '1) count_q <= count_q + COUNT_WIDTH'(1);
                        end
                    end
                    HIT:     state_q <= DONE;
                    default: state_q <= state_q;   // IDLE/DONE wait for a frame
                endcase
            end
        end
    end

    assign collisionPulse  = pulse_q;
    assign collidedTreeIdx = idx_q;
    assign playerBlocked   = blocked_q;
    assign collisionCount  = count_q;

endmodule

// File: tb/tb_tree_collision_detector.sv
module tb_tree_collision_detector;

    localparam int TC   = 16;
    localparam int MINO = 4;
`ifdef TREE_COLLISION_DEBOUNCE_EN
    localparam int QUAL = MINO;
`else
    localparam int QUAL = 1;
`endif

    logic          clk = 1'b0;
    logic          resetN = 1'b1;
    logic          sof = 1'b0, pdr = 1'b0, tdr = 1'b0;
    logic [TC-1:0] rect = '0;

    logic          pulse_a, blk_a, pulse_b, blk_b;
    logic [3:0]    idx_a, idx_b;
    logic [7:0]    cnt_a;
    logic [1:0]    cnt_b;

    always #5 clk = ~clk;

    tree_collision_detector #(.TREES_COUNT(TC), .COUNT_WIDTH(8), .MIN_OVERLAP(MINO)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .playerDrawingRequest(pdr), .treesDrawingRequest(tdr),
        .treesInsideRectangle(rect),
        .collisionPulse(pulse_a), .collidedTreeIdx(idx_a),
        .playerBlocked(blk_a), .collisionCount(cnt_a));

    tree_collision_detector #(.TREES_COUNT(TC), .COUNT_WIDTH(2), .MIN_OVERLAP(MINO)) dut_sat (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .playerDrawingRequest(pdr), .treesDrawingRequest(tdr),
        .treesInsideRectangle(rect),
        .collisionPulse(pulse_b), .collidedTreeIdx(idx_b),
        .playerBlocked(blk_b), .collisionCount(cnt_b));

    // Reference model: frame-level view of the rules.
    // m_mode: 0 = no frame seen since reset, 1 = frame open, 2 = already hit.
    int n_assert = 0, n_fail = 0, pulses_seen = 0;
    int m_mode, m_run, m_cnt, m_idx;
    bit m_pulse, m_blk;

    function automatic int lowest(input logic [TC-1:0] v);
        for (int i = 0; i < TC; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_cnt = 0; m_idx = 0; m_pulse = 0; m_blk = 0;
    endtask

    task automatic model_edge(input bit s, input bit ov, input logic [TC-1:0] r);
        m_pulse = 0;
        if (s) begin
            m_mode = 1; m_run = 0; m_blk = 0;
        end else if (m_mode == 1) begin
            if (ov) begin
                m_run++;
                if (m_run >= QUAL) begin
                    m_pulse = 1; m_mode = 2; m_blk = 1; m_cnt++; m_run = 0;
                    if (lowest(r) >= 0) m_idx = lowest(r);
                end
            end else m_run = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string w);
        chk({w, ".pulse"},   32'(pulse_a), 32'(m_pulse));
        chk({w, ".blocked"}, 32'(blk_a),   32'(m_blk));
        chk({w, ".idx"},     32'(idx_a),   32'(m_idx));
        chk({w, ".count"},   32'(cnt_a),   32'(sat(m_cnt, 255)));
        chk({w, ".s_pulse"}, 32'(pulse_b), 32'(m_pulse));
        chk({w, ".s_blk"},   32'(blk_b),   32'(m_blk));
        chk({w, ".s_idx"},   32'(idx_b),   32'(m_idx));
        chk({w, ".s_count"}, 32'(cnt_b),   32'(sat(m_cnt, 3)));
    endtask

    // Drive one pixel cycle, advance model on the edge, check 1 unit later.
    task automatic cyc(input string w, input bit s, input bit p, input logic [TC-1:0] r, input bit t);
        sof = s; pdr = p; rect = r; tdr = t;
        @(posedge clk);
        model_edge(s, p && t, r);
        #1;
        check_all(w);
        if (pulse_a === 1'b1) pulses_seen++;
    endtask

    task automatic frame(input string w);       cyc(w, 1, 0, '0, 0); endtask
    task automatic idle(input string w);        cyc(w, 0, 0, '0, 0); endtask
    task automatic ov(input string w, input logic [TC-1:0] r); cyc(w, 0, 1, r, |r); endtask

    task automatic do_reset(input string w);
        sof = 0; pdr = 0; tdr = 0; rect = '0;
        resetN = 1'b0;
        model_reset();
        #1;
        check_all(w);
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    int exp_sat[5] = '{1, 2, 3, 3, 3};

    initial begin
        #2;
        // Reset state
        do_reset("reset");
        idle("post_reset");
        ov("ovl_in_idle", 16'h0001);

        // Basic hit
        frame("basic.sof");
        repeat (QUAL) ov("basic.ov", 16'h0028);
        chk("basic.pulse_one", 32'(pulse_a), 32'd1);
        chk("basic.idx3",      32'(idx_a),   32'd3);
        chk("basic.count1",    32'(cnt_a),   32'd1);
        chk("basic.blocked",   32'(blk_a),   32'd1);
        idle("basic.after");
        chk("basic.pulse_drop", 32'(pulse_a), 32'd0);

        // One pulse per frame
        frame("once.sof");
        pulses_seen = 0;
        for (int i = 0; i < 5; i++) begin
            repeat (QUAL) ov("once.ov", 16'h0400);
            idle("once.gap");
        end
        chk("once.pulses", 32'(pulses_seen), 32'd1);
        chk("once.count",  32'(cnt_a),       32'd2);
        chk("once.idx",    32'(idx_a),       32'd10);
        chk("once.blk_hold", 32'(blk_a),     32'd1);
        frame("once.next_sof");
        chk("once.blk_clear", 32'(blk_a),    32'd0);

        // Frame-start priority over same-cycle overlap
        cyc("prio.sof_ov", 1, 1, 16'h0100, 1);
        chk("prio.no_pulse", 32'(pulse_a), 32'd0);
        repeat (QUAL) ov("prio.ov", 16'h0100);
        chk("prio.pulse", 32'(pulse_a), 32'd1);
        chk("prio.idx8",  32'(idx_a),   32'd8);
        // startOfFrame during the HIT cycle re-arms immediately
        frame("prio.sof_in_hit");
        repeat (QUAL) ov("prio.rehit", 16'h0003);
        chk("prio.rehit_pulse", 32'(pulse_a), 32'd1);
        chk("prio.rehit_idx",   32'(idx_a),   32'd0);

        // Saturation of the 2-bit counter
        do_reset("sat.reset");
        for (int f = 0; f < 5; f++) begin
            frame("sat.sof");
            repeat (QUAL) ov("sat.ov", 16'h8000);
            chk("sat.count", 32'(cnt_b), 32'(exp_sat[f]));
            idle("sat.gap");
        end
        chk("sat.idx15", 32'(idx_b), 32'd15);

        // Reset during the HIT cycle
        frame("rst.sof");
        repeat (QUAL) ov("rst.ov", 16'h0040);
        chk("rst.in_hit", 32'(pulse_a), 32'd1);
        do_reset("rst.mid_hit");
        chk("rst.pulse0", 32'(pulse_a), 32'd0);
        chk("rst.blk0",   32'(blk_a),   32'd0);
        chk("rst.cnt0",   32'(cnt_a),   32'd0);
        pulses_seen = 0;
        repeat (QUAL + 2) ov("rst.ov_before_sof", 16'h0040);
        chk("rst.no_pulse", 32'(pulses_seen), 32'd0);
        frame("rst.sof2");
        repeat (QUAL) ov("rst.resume", 16'h0040);
        chk("rst.resume_pulse", 32'(pulse_a), 32'd1);

`ifdef TREE_COLLISION_DEBOUNCE_EN
        // Debounce: run of 3 does not qualify, following run of 4 does
        frame("deb.sof");
        pulses_seen = 0;
        repeat (3) ov("deb.run3", 16'h0200);
        idle("deb.gap");
        repeat (3) ov("deb.run4a", 16'h0200);
        chk("deb.no_early", 32'(pulses_seen), 32'd0);
        ov("deb.run4b", 16'h0200);
        chk("deb.pulse", 32'(pulse_a), 32'd1);
        chk("deb.idx9",  32'(idx_a),   32'd9);
        // Run broken by a frame start restarts the count
        frame("deb.sof2");
        repeat (3) ov("deb.pre", 16'h0002);
        frame("deb.sof3");
        ov("deb.post", 16'h0002);
        chk("deb.restart", 32'(pulse_a), 32'd0);
`endif

        // Randomized traffic against the model
        do_reset("rnd.reset");
        for (int n = 0; n < 800; n++) begin
            logic [TC-1:0] r;
            bit s, p;
            r = TC'($urandom & $urandom & $urandom);
            s = ($urandom_range(0, 29) == 0);
            p = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 249) == 0) do_reset("rnd.reset_mid");
            else cyc("rnd", s, p, r, |r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
